fir_mac_sequencer: RTL and testbench

Folded-FIR controller that time-multiplexes one shared signed multiplier, instantiated outside this block, across N_TAPS taps.
- Owns the circular sample history, the coefficient register file, the tap counter, the accumulator and the in/out valid/ready handshakes.
- Sits between the sample source and the downstream consumer.
- Replaces the fully parallel filter where area matters more than throughput.

---
 rtl/fir_mac_sequencer.sv | 136 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Folded FIR controller: one external signed multiplier shared across N_TAPS taps; SYMMETRIC_FOLD_EN pre-adds mirrored taps.
// Latency: accept at T, out_valid at T+N_TAPS+1 (T+N_TAPS/2+1 folded); one sample per MAC_LEN+2 cycles with out_ready high.
// Backpressure: in_ready only in IDLE; out_data held stable in DONE until out_valid & out_ready.
module fir_mac_sequencer #(
    parameter int N_TAPS = 8,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 33,
`ifdef SYMMETRIC_FOLD_EN
    parameter int MA_W   = DATA_W + 1
`else
    parameter int MA_W   = DATA_W
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      coef_we,
    input  logic [$clog2(N_TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]         coef_data,
    output logic [MA_W-1:0]           mul_a,
    output logic [COEF_W-1:0]         mul_b,
    input  logic [MA_W+COEF_W-1:0]    mul_p,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic                      busy
);
    localparam int KW = $clog2(N_TAPS);
`ifdef SYMMETRIC_FOLD_EN
    localparam int MAC_LEN = N_TAPS / 2;
`else
    localparam int MAC_LEN = N_TAPS;
`endif
    localparam logic [KW-1:0] K_LAST = KW'(MAC_LEN - 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] hist [N_TAPS];
    logic [COEF_W-1:0] coef [N_TAPS];
    logic [KW-1:0]     wr_ptr;
    logic [KW-1:0]     newest;
    logic [KW-1:0]     k;
    logic [KW-1:0]     tap_idx;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  acc_next;
    logic              coef_ok;

    assign tap_idx  = newest - k;
    assign prod_ext = ACC_W'($signed(mul_p));
    assign acc_next = (k == '0) ? prod_ext : acc + prod_ext;

`ifdef SYMMETRIC_FOLD_EN
    // Only the lower half of the coefficient table exists; the mirror tap is newest-(N_TAPS-1-k).
    logic [KW-1:0] mirror_idx;
    assign mirror_idx = newest + k + KW'(1);
    assign coef_ok    = !coef_addr[KW-1];
`else
    assign coef_ok    = 1'b1;
`endif

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == MAC) begin
`ifdef SYMMETRIC_FOLD_EN
            mul_a = MA_W'($signed(hist[tap_idx])) + MA_W'($signed(hist[mirror_idx]));
`else
            mul_a = hist[tap_idx];
`endif
            mul_b = coef[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            wr_ptr    <= '0;
            newest    <= '0;
            k         <= '0;
            acc       <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
        end else begin
            // A write landing in the same cycle as an accept is seen by that sample's MAC.
            if (state == IDLE && coef_we && coef_ok) begin
                coef[coef_addr] <= coef_data;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hist[wr_ptr] <= in_data;
                        newest       <= wr_ptr;
                        wr_ptr       <= wr_ptr + KW'(1);
                        k            <= '0;
                        state        <= MAC;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (k == K_LAST) begin
                        k         <= '0;
                        out_data  <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: directed scenarios plus a random phase, scored against a sum-of-products reference model.
module tb_fir_mac_sequencer;
    localparam int N_TAPS = 8;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int ACC_W  = 33;
    localparam int KW     = $clog2(N_TAPS);
`ifdef SYMMETRIC_FOLD_EN
    localparam int MA_W    = DATA_W + 1;
    localparam int MAC_LEN = N_TAPS / 2;
`else
    localparam int MA_W    = DATA_W;
    localparam int MAC_LEN = N_TAPS;
`endif
    localparam int P_W = MA_W + COEF_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              coef_we;
    logic [KW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic [MA_W-1:0]   mul_a;
    logic [COEF_W-1:0] mul_b;
    logic [P_W-1:0]    mul_p;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              busy;

    fir_mac_sequencer #(.N_TAPS(N_TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    // The external multiplier the block expects.
    assign mul_p = P_W'($signed(mul_a)) * P_W'($signed(mul_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [DATA_W-1:0] hist_q[$];
    logic signed [COEF_W-1:0] coef_m [N_TAPS];
    logic [ACC_W-1:0]         exp_q[$];
    int                       due_q[$];
    logic [ACC_W-1:0]         out_log[$];
    int                       acc_log[$];
    int                       last_acc = -1;
    int                       last_rel = 0;
    bit                       holding = 1'b0;
    int                       checks = 0;
    int                       errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    function automatic longint coef_of(input int k);
`ifdef SYMMETRIC_FOLD_EN
        int j = (k < N_TAPS / 2) ? k : N_TAPS - 1 - k;
`else
        int j = k;
`endif
        return longint'(coef_m[j]);
    endfunction

    // y[n] = sum_k coef[k] * x[n-k], samples before the first accept count as zero.
    function automatic logic [ACC_W-1:0] model_y();
        longint s = 0;
        int n = hist_q.size() - 1;
        for (int k = 0; k < N_TAPS; k++) begin
            if (n - k >= 0) s += longint'(hist_q[n-k]) * coef_of(k);
        end
        return s[ACC_W-1:0];
    endfunction

    // Input side: decides whether the block is idle, applies writes, and queues the expected result.
    always @(negedge clk) begin : in_mon
        bit idle;
        bit wr_ok;
        if (!reset) begin
            hist_q.delete();
            foreach (coef_m[i]) coef_m[i] = '0;
            last_acc = -1;
            last_rel = cyc;
        end else begin
            idle = (last_rel > last_acc) && (last_rel < cyc);
`ifdef SYMMETRIC_FOLD_EN
            wr_ok = (int'(coef_addr) < N_TAPS / 2);
`else
            wr_ok = 1'b1;
`endif
            check("in_ready", 64'(in_ready), 64'(idle));
            check("busy", 64'(busy), 64'(!idle));
            if (idle && coef_we && wr_ok) coef_m[coef_addr] = coef_data;
            if (idle && in_valid) begin
                hist_q.push_back(in_data);
                exp_q.push_back(model_y());
                due_q.push_back(cyc + MAC_LEN + 1);
                last_acc = cyc;
            end
        end
    end

    // Output side: pops and compares whenever a result is presented.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            due_q.delete();
            holding = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_spurious at cycle %0d: got out_valid=1 data %h, want no output", cyc, out_data);
            end else begin
                if (!holding) check("latency", 64'(cyc), 64'(due_q[0]));
                holding = 1'b1;
                check("out_data", 64'(out_data), 64'(exp_q[0]));
                if (out_ready) begin
                    out_log.push_back(out_data);
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                    holding  = 1'b0;
                    last_rel = cyc;
                end
            end
        end else if (due_q.size() > 0 && cyc > due_q[0]) begin
            checks++;
            errors++;
            $display("FAIL out_timeout at cycle %0d: got out_valid=0, want result due at cycle %0d", cyc, due_q[0]);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            holding  = 1'b0;
            last_rel = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain at cycle %0d: got %0d results pending, want 0", cyc, exp_q.size());
        end
        tick();
    endtask

    // Leaves in_valid high so back-to-back calls present samples without a gap.
    task automatic send(input logic [DATA_W-1:0] x);
        int n = 0;
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout at cycle %0d: got in_ready=0, want an accept", cyc);
        end else begin
            acc_log.push_back(cyc);
        end
        tick();
    endtask

    task automatic write_coef(input int a, input logic [COEF_W-1:0] d);
        coef_we   = 1'b1;
        coef_addr = KW'(a);
        coef_data = d;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic impulse_run();
        for (int k = 0; k < N_TAPS; k++) write_coef(k, COEF_W'(k + 1));
        out_log.delete();
        acc_log.delete();
        send(DATA_W'(1));
        for (int i = 0; i < 9; i++) send('0);
        in_valid = 1'b0;
        drain();
`ifndef SYMMETRIC_FOLD_EN
        for (int i = 0; i < 10; i++) check("impulse_seq", 64'(out_log[i]), (i < 8) ? 64'(i + 1) : 64'(0));
`endif
        for (int i = 1; i < 10; i++) check("accept_spacing", 64'(acc_log[i] - acc_log[i-1]), 64'(MAC_LEN + 2));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog at cycle %0d: got no finish, want bench completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_mul_a", 64'(mul_a), 64'(0));
        check("rst_mul_b", 64'(mul_b), 64'(0));
        tick();

        impulse_run();

        // Near-full-scale DC, positive then negative.
        for (int k = 0; k < N_TAPS; k++) write_coef(k, 16'h4000);
        for (int i = 0; i < 10; i++) send(16'h7FFF);
        in_valid = 1'b0;
        drain();
        check("dc_pos", 64'(out_log[out_log.size()-1]), 64'h0_FFFE_0000);
        for (int i = 0; i < 8; i++) send(16'h8000);
        in_valid = 1'b0;
        drain();
        check("dc_neg", 64'(out_log[out_log.size()-1]), 64'h1_0000_0000);

        // Output stalled with the next sample already offered.
        out_ready = 1'b0;
        send(16'h1234);
        repeat (MAC_LEN + 6) tick();
        check("stall_out_valid", 64'(out_valid), 64'(1));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        in_data   = 16'h0042;
        out_ready = 1'b1;
        send(16'h0042);
        in_valid = 1'b0;
        drain();

        // Coefficient write during MAC is dropped; the same write with an accept is used.
        send(16'h0100);
        in_valid = 1'b0;
        write_coef(0, 16'h7000);
        drain();
        send(16'h0001);
        in_valid = 1'b0;
        drain();
        coef_we = 1'b1; coef_addr = '0; coef_data = 16'h0300;
        send(16'h0005);
        coef_we  = 1'b0;
        in_valid = 1'b0;
        drain();

        // Reset during tap 3 discards everything.
        send(16'h0777);
        in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        tick();
        impulse_run();

        // History pointer wrap with a first/last-tap filter.
        for (int k = 0; k < N_TAPS; k++) write_coef(k, (k == 0 || k == N_TAPS - 1) ? COEF_W'(1) : '0);
        for (int i = 1; i <= 20; i++) send(DATA_W'(i));
        in_valid = 1'b0;
        drain();
        check("wrap_last", 64'(out_log[out_log.size()-1]), 64'(33));

        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 199) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = DATA_W'($urandom);
            coef_we   = ($urandom_range(0, 4) == 0);
            coef_addr = KW'($urandom);
            coef_data = COEF_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
